// File: rtl/y86_pipe_ctl.sv
// rtl/y86_pipe_ctl.sv - Y86-64 five-stage pipeline control: stall/bubble, CC gating, status FSM
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined;
// otherwise cyc_cnt/ret_cnt/mis_cnt/stl_cnt are tied to zero.
module y86_pipe_ctl #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WDOG_LIMIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       m_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       w_stat,
  input  logic             w_valid,
  output logic             f_stall,
  output logic             d_stall,
  output logic             d_bubble,
  output logic             e_bubble,
  output logic             m_bubble,
  output logic             w_stall,
  output logic             set_cc,
  output logic [2:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] stl_cnt
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [2:0] S_TMO    = 3'd5;

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cpu_stat_q, cpu_stat_d;
  logic        halted_q, halted_d;
  logic [31:0] idle_q, idle_d;

  logic load_use, ret_hz, mispred, m_exc, w_exc, retire, run, wdog_hit;

  // Hazard detection from the instructions currently in D/E/M/W
  always_comb begin
    load_use = (e_icode == I_MRMOVQ || e_icode == I_POPQ) && (e_dstM != R_NONE) &&
               (e_dstM == d_srcA || e_dstM == d_srcB);
    ret_hz   = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
    mispred  = (e_icode == I_JXX) && !e_cnd;
    m_exc    = (m_stat != S_AOK);
    w_exc    = w_valid && (w_stat != S_AOK);
    retire   = w_valid && (w_stat == S_AOK);
    run      = (state_q == ST_RUN);
  end

  // Per-stage stall/bubble and CC enable; HALTED freezes the whole pipe
  always_comb begin
    f_stall  = 1'b1;
    d_stall  = 1'b1;
    d_bubble = 1'b0;
    e_bubble = 1'b1;
    m_bubble = 1'b1;
    w_stall  = 1'b1;
    set_cc   = 1'b0;
    if (run) begin
      f_stall  = load_use || ret_hz;
      d_stall  = load_use;
      d_bubble = mispred || (ret_hz && !load_use);
      e_bubble = mispred || load_use;
      m_bubble = m_exc || w_exc;
      w_stall  = w_exc;
      set_cc   = (e_icode == I_OPQ) && !(m_exc || w_exc);
    end
  end

  // Watchdog idle counter and status FSM next-state; a retiring exception beats a timeout
  always_comb begin
    state_d    = state_q;
    cpu_stat_d = cpu_stat_q;
    halted_d   = halted_q;
    idle_d     = idle_q;
    wdog_hit   = 1'b0;
    if (run) begin
      if (retire) begin
        idle_d = 32'd0;
      end else if (idle_q != 32'hFFFF_FFFF) begin
        idle_d = idle_q + 32'd1;
      end
      wdog_hit = (WDOG_LIMIT != 0) && !retire && (idle_q + 32'd1 >= WDOG_LIMIT);
      if (w_exc) begin
        state_d    = ST_HALTED;
        cpu_stat_d = w_stat;
        halted_d   = 1'b1;
      end else if (wdog_hit) begin
        state_d    = ST_HALTED;
        cpu_stat_d = S_TMO;
        halted_d   = 1'b1;
      end
    end
  end

  // Status FSM state and its registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cpu_stat_q <= S_AOK;
      halted_q   <= 1'b0;
      idle_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cpu_stat_q <= cpu_stat_d;
      halted_q   <= halted_d;
      idle_q     <= idle_d;
    end
  end

  assign cpu_stat = cpu_stat_q;
  assign halted   = halted_q;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, mis_q, mis_d, stl_q, stl_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_ONE : v;
  endfunction

  // Saturating event counters, advancing only while running
  always_comb begin
    cyc_d = sat_inc(cyc_q, run);
    ret_d = sat_inc(ret_q, run && retire);
    mis_d = sat_inc(mis_q, run && mispred);
    stl_d = sat_inc(stl_q, run && load_use);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
      mis_q <= '0;
      stl_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
      mis_q <= mis_d;
      stl_q <= stl_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
  assign mis_cnt = mis_q;
  assign stl_cnt = stl_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
  assign mis_cnt = '0;
  assign stl_cnt = '0;
`endif

endmodule
